// File: rtl/pbit_pkg.sv
// -----------------------------------------------------------------------------
// pbit_pkg
// Shared definitions for the P-bit network blocks (readout and clamp callers).
//   NUM_PBITS_DEFAULT / NUM_OUT_DEFAULT : default network and output widths
//   readout_state_t                     : readout FSM state encoding
//   out_index()                         : state-vector index of output bit i
//   near_tie()                          : low-confidence test for one bit
// -----------------------------------------------------------------------------
package pbit_pkg;

  localparam int NUM_PBITS_DEFAULT = 53;
  localparam int NUM_OUT_DEFAULT   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } readout_state_t;

  // Output P-bits occupy the top num_out indices of the state vector.
  function automatic int out_index(input int i,
                                   input int num_pbits = NUM_PBITS_DEFAULT,
                                   input int num_out   = NUM_OUT_DEFAULT);
    return num_pbits - num_out + i;
  endfunction

  // True when |2*ones - num_samples| < num_samples/8, i.e. the vote was close.
  function automatic logic near_tie(input int ones, input int num_samples);
    int dev;
    dev = 2 * ones - num_samples;
    return (dev < 0) ? ((-dev) < (num_samples / 8)) : (dev < (num_samples / 8));
  endfunction

endpackage

// File: rtl/pbit_readout_if.sv
// -----------------------------------------------------------------------------
// pbit_readout_if
// Result handshake between the P-bit readout and the controller/UART path.
//   result       : majority-voted output word, index 0..NUM_OUT-1
//   result_valid : result available (producer -> consumer)
//   result_ready : consumer accepts result (consumer -> producer)
//   low_conf     : some bit voted close to a tie (only with
//                  PBIT_READOUT_CONFIDENCE_EN defined)
// Modports: master = readout side, slave = consumer side.
// -----------------------------------------------------------------------------
interface pbit_readout_if
  import pbit_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEFAULT
) ();

  logic [0:NUM_OUT-1] result;
  logic               result_valid;
  logic               result_ready;

`ifdef PBIT_READOUT_CONFIDENCE_EN
  logic               low_conf;

  modport master (output result, output result_valid, output low_conf,
                  input  result_ready);
  modport slave  (input  result, input  result_valid, input  low_conf,
                  output result_ready);
`else
  modport master (output result, output result_valid,
                  input  result_ready);
  modport slave  (input  result, input  result_valid,
                  output result_ready);
`endif

endinterface

// File: rtl/pbit_ones_counter.sv
// -----------------------------------------------------------------------------
// pbit_ones_counter
// Per-bit ones counter: synchronous clear has priority over the count enable.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear counter to zero
//   en_i     : increment by one
//   cnt_o    : registered count
// -----------------------------------------------------------------------------
module pbit_ones_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pbit_readout.sv
// -----------------------------------------------------------------------------
// pbit_readout
// Time-averages the output P-bits over NUM_SAMPLES sample strobes (after
// SETTLE_SAMPLES discarded burn-in strobes) and returns a strict-majority
// vote per bit over a valid/ready handshake.
//   clk, rst    : clock, asynchronous active-high reset
//   start_i     : single-cycle readout request (honoured in IDLE only)
//   sample_en_i : P-bit states valid this cycle
//   m_i         : live P-bit state vector, index 0..NUM_PBITS-1
//   busy_o      : high while settling or accumulating
//   res_if      : result / result_valid / result_ready (+ low_conf)
// Optional feature macro: PBIT_READOUT_CONFIDENCE_EN adds res_if.low_conf.
// -----------------------------------------------------------------------------
module pbit_readout
  import pbit_pkg::*;
#(
  parameter int NUM_PBITS      = NUM_PBITS_DEFAULT,
  parameter int NUM_OUT        = NUM_OUT_DEFAULT,
  parameter int NUM_SAMPLES    = 256,
  parameter int SETTLE_SAMPLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 sample_en_i,
  input  logic [0:NUM_PBITS-1] m_i,
  output logic                 busy_o,
  pbit_readout_if.master       res_if
);

  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  localparam logic [CW-1:0] LAST_SAMPLE = CW'(NUM_SAMPLES - 1);
  localparam logic [SW-1:0] LAST_SETTLE = (SETTLE_SAMPLES > 0) ? SW'(SETTLE_SAMPLES - 1) : '0;
  localparam logic [CW:0]   HALF        = (CW + 1)'(NUM_SAMPLES / 2);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETTLE = SETTLE;
  localparam logic [1:0] ST_ACCUM  = ACCUM;
  localparam logic [1:0] ST_DONE   = DONE;
  localparam logic [1:0] ST_FIRST  = (SETTLE_SAMPLES > 0) ? ST_SETTLE : ST_ACCUM;

  logic [1:0]         state_q, state_d;
  logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]      sample_cnt_q, sample_cnt_d;
  logic [0:NUM_OUT-1] result_q, result_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               cnt_clr;
  logic               cnt_en;
  logic [0:NUM_OUT-1] out_bits;
  logic [0:NUM_OUT-1] vote;
`ifdef PBIT_READOUT_CONFIDENCE_EN
  logic               low_conf_q, low_conf_d;
  logic [0:NUM_OUT-1] near;
`endif

  // The vote is taken on the edge that accumulates the last strobe, so it
  // uses each counter's value including that strobe (count + current bit).
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_bit
    localparam int IDX = out_index(g, NUM_PBITS, NUM_OUT);
    logic [CW-1:0] ones_cnt;
    logic [CW:0]   final_cnt;

    assign out_bits[g] = m_i[IDX];

    pbit_ones_counter #(.W(CW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en & out_bits[g]),
      .cnt_o (ones_cnt)
    );

    assign final_cnt = {1'b0, ones_cnt} + {{CW{1'b0}}, out_bits[g]};
    assign vote[g]   = (final_cnt > HALF);
`ifdef PBIT_READOUT_CONFIDENCE_EN
    assign near[g]   = near_tie(int'(final_cnt), NUM_SAMPLES);
`endif
  end

  // Readout FSM: settle, accumulate, then hold the result until accepted.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    sample_cnt_d = sample_cnt_q;
    result_d     = result_q;
    valid_d      = valid_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
`ifdef PBIT_READOUT_CONFIDENCE_EN
    low_conf_d   = low_conf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_clr      = 1'b1;
          sample_cnt_d = '0;
          settle_cnt_d = '0;
          state_d      = ST_FIRST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // The strobe that completes burn-in is discarded, not accumulated.
        if (sample_en_i) begin
          if (settle_cnt_q == LAST_SETTLE) begin
            settle_cnt_d = '0;
            state_d      = ST_ACCUM;
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1'b1);
          end
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_ACCUM: begin
        if (sample_en_i) begin
          cnt_en       = 1'b1;
          sample_cnt_d = sample_cnt_q + CW'(1'b1);
          if (sample_cnt_q == LAST_SAMPLE) begin
            state_d  = ST_DONE;
            result_d = vote;
            valid_d  = 1'b1;
`ifdef PBIT_READOUT_CONFIDENCE_EN
            low_conf_d = |near;
`endif
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here, even on the accept cycle.
        if (valid_q && res_if.result_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
`ifdef PBIT_READOUT_CONFIDENCE_EN
          low_conf_d = 1'b0;
`endif
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_ACCUM);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      result_q     <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PBIT_READOUT_CONFIDENCE_EN
      low_conf_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
`ifdef PBIT_READOUT_CONFIDENCE_EN
      low_conf_q   <= low_conf_d;
`endif
    end
  end

  assign busy_o              = busy_q;
  assign res_if.result       = result_q;
  assign res_if.result_valid = valid_q;
`ifdef PBIT_READOUT_CONFIDENCE_EN
  assign res_if.low_conf     = low_conf_q;
`endif

endmodule

// File: tb/tb_pbit_readout.sv
`timescale 1ns/1ps
module tb_pbit_readout;

  localparam int NP = 53;
  localparam int NO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default-configuration DUT (256 samples, 16 burn-in).
  logic          start_b, sen_b, busy_b;
  logic [0:NP-1] m_b;
  pbit_readout_if #(.NUM_OUT(NO)) if_b ();
  pbit_readout #(.NUM_PBITS(NP), .NUM_OUT(NO), .NUM_SAMPLES(256), .SETTLE_SAMPLES(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_b), .sample_en_i(sen_b),
    .m_i(m_b), .busy_o(busy_b), .res_if(if_b.master));

  // Small DUT (4 samples, no burn-in) for the tie/majority table.
  logic          start_s, sen_s, busy_s;
  logic [0:NP-1] m_s;
  pbit_readout_if #(.NUM_OUT(NO)) if_s ();
  pbit_readout #(.NUM_PBITS(NP), .NUM_OUT(NO), .NUM_SAMPLES(4), .SETTLE_SAMPLES(0)) dut_s (
    .clk(clk), .rst(rst), .start_i(start_s), .sample_en_i(sen_s),
    .m_i(m_s), .busy_o(busy_s), .res_if(if_s.master));

  typedef struct packed {
    logic [3:0][0:7] pats;
    logic [0:7]      exp;
  } vec_t;

  vec_t       vecs [6];
  logic [0:7] sb_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic vec_t mk(input logic [0:7] a, input logic [0:7] b,
                              input logic [0:7] c, input logic [0:7] d,
                              input logic [0:7] e);
    vec_t r;
    r.pats[0] = a; r.pats[1] = b; r.pats[2] = c; r.pats[3] = d;
    r.exp = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random background on non-output bits; output bit i lives at index 45+i.
  task automatic set_out_b(input logic [0:7] p);
    for (int k = 0; k < NP; k++) m_b[k] = 1'($urandom_range(0, 1));
    for (int i = 0; i < NO; i++) m_b[45 + i] = p[i];
  endtask

  task automatic strobe_b(input logic [0:7] p);
    set_out_b(p);
    sen_b = 1'b1;
    tick();
    sen_b = 1'b0;
  endtask

  task automatic start_pulse_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  // Wait (bounded) for result_valid, then compare against the scoreboard head.
  task automatic wait_result_b(input string name);
    logic [0:7] e;
    for (int k = 0; k < 50 && !if_b.result_valid; k++) tick();
    if (!if_b.result_valid) begin
      chk({name, "_timeout"}, 32'(if_b.result_valid), 32'd1);
    end else if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(name, 32'(if_b.result), 32'(e));
    end
  endtask

  task automatic accept_b(input string name);
    if_b.result_ready = 1'b1;
    tick();
    if_b.result_ready = 1'b0;
    chk({name, "_valid_drop"}, 32'(if_b.result_valid), 32'd0);
    chk({name, "_busy_idle"}, 32'(busy_b), 32'd0);
  endtask

  initial begin
    logic [0:7] p;
    logic [0:7] q;
    rst = 1'b1;
    start_b = 1'b0; sen_b = 1'b0; m_b = '0; if_b.result_ready = 1'b0;
    start_s = 1'b0; sen_s = 1'b0; m_s = '0; if_s.result_ready = 1'b0;

    vecs[0] = mk(8'b1000_0000, 8'b1100_0000, 8'b0100_0000, 8'b0100_0000, 8'b0100_0000);
    vecs[1] = mk(8'b1111_1111, 8'b1111_1111, 8'b1111_1111, 8'b1111_1111, 8'b1111_1111);
    vecs[2] = mk(8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    vecs[3] = mk(8'b0000_1111, 8'b0000_1111, 8'b1111_0000, 8'b0000_1111, 8'b0000_1111);
    vecs[4] = mk(8'b1010_1010, 8'b0101_0101, 8'b1010_1010, 8'b0101_0101, 8'b0000_0000);
    vecs[5] = mk(8'b1000_0001, 8'b1000_0001, 8'b0000_0000, 8'b1000_0001, 8'b1000_0001);

    // Reset state.
    tick(); tick();
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_valid", 32'(if_b.result_valid), 32'd0);
    chk("rst_result", 32'(if_b.result), 32'd0);
    chk("rst_valid_s", 32'(if_s.result_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Tie / majority table on the 4-sample DUT.
    for (int v = 0; v < 6; v++) begin
      sb_q.push_back(vecs[v].exp);
      start_s = 1'b1; tick(); start_s = 1'b0;
      chk($sformatf("tab%0d_busy", v), 32'(busy_s), 32'd1);
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < NO; i++) m_s[45 + i] = vecs[v].pats[k][i];
        sen_s = 1'b1;
        tick();
      end
      sen_s = 1'b0;
      chk($sformatf("tab%0d_valid", v), 32'(if_s.result_valid), 32'd1);
      q = sb_q.pop_front();
      chk($sformatf("tab%0d_result", v), 32'(if_s.result), 32'(q));
      if_s.result_ready = 1'b1; tick(); if_s.result_ready = 1'b0;
      chk($sformatf("tab%0d_drop", v), 32'(if_s.result_valid), 32'd0);
    end

    // Constant pattern, strobe every cycle, exact latency.
    p = 8'b1011_0010;
    sb_q.push_back(p);
    start_pulse_b();
    chk("const_busy", 32'(busy_b), 32'd1);
    for (int k = 0; k < 271; k++) strobe_b(p);
    chk("const_early_valid", 32'(if_b.result_valid), 32'd0);
    chk("const_busy_accum", 32'(busy_b), 32'd1);
    strobe_b(p);
    chk("const_latency", 32'(if_b.result_valid), 32'd1);
    chk("const_busy_done", 32'(busy_b), 32'd0);
    wait_result_b("const_result");
`ifdef PBIT_READOUT_CONFIDENCE_EN
    chk("const_low_conf", 32'(if_b.low_conf), 32'd0);
`endif
    accept_b("const");

    // Handshake hold with start pulses, then start coincident with accept.
    q = 8'b0110_0111;
    sb_q.push_back(q);
    start_pulse_b();
    for (int k = 0; k < 272; k++) strobe_b(q);
    wait_result_b("hold_result");
    for (int c = 0; c < 50; c++) begin
      start_b = (c % 7 == 3);
      tick();
      chk("hold_result_stable", 32'(if_b.result), 32'(q));
      chk("hold_valid_stable", 32'(if_b.result_valid), 32'd1);
    end
    start_b = 1'b1;
    accept_b("hold");
    start_b = 1'b0;
    tick(); tick();
    chk("hold_start_not_queued", 32'(busy_b), 32'd0);
    chk("hold_result_kept", 32'(if_b.result), 32'(q));

    // Burn-in discard: ones during settle; bit0 ties at 128, bit1 gets 129.
    sb_q.push_back(8'b0100_0000);
    start_pulse_b();
    for (int k = 0; k < 16; k++) strobe_b(8'b1111_1111);
    for (int k = 0; k < 256; k++) begin
      p = '0;
      p[0] = (k < 128);
      p[1] = (k >= 127);
      if (k == 255) chk("settle_early_valid", 32'(if_b.result_valid), 32'd0);
      strobe_b(p);
    end
    wait_result_b("settle_result");
    accept_b("settle");

    // Gap strobes every 3rd cycle, start during ACCUM; bit0 at 130/256.
    sb_q.push_back(8'b1000_0001);
    start_pulse_b();
    for (int k = 0; k < 16; k++) begin
      strobe_b(8'b1111_1111);
      tick(); tick();
    end
    for (int k = 0; k < 256; k++) begin
      p = '0;
      p[0] = (k < 130);
      p[7] = 1'b1;
      strobe_b(p);
      if (k == 50) start_b = 1'b1;
      tick();
      start_b = 1'b0;
      if (k == 254) chk("gap_early_valid", 32'(if_b.result_valid), 32'd0);
      if (k < 255) tick();
    end
    chk("gap_busy_done", 32'(busy_b), 32'd0);
    wait_result_b("gap_result");
`ifdef PBIT_READOUT_CONFIDENCE_EN
    chk("gap_low_conf", 32'(if_b.low_conf), 32'd1);
`endif
    accept_b("gap");

    // Reset mid-ACCUM after 100 strobes of all ones, then a fresh readout.
    start_pulse_b();
    for (int k = 0; k < 16 + 100; k++) strobe_b(8'b1111_1111);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_b), 32'd0);
    chk("midrst_valid", 32'(if_b.result_valid), 32'd0);
    chk("midrst_result", 32'(if_b.result), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    sb_q.push_back(8'b0001_1000);
    start_pulse_b();
    for (int k = 0; k < 16; k++) strobe_b(8'b0000_0000);
    for (int k = 0; k < 256; k++) begin
      p = 8'b0001_1000;
      p[0] = (k < 128);
      strobe_b(p);
    end
    wait_result_b("midrst_fresh_result");
    accept_b("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
